// File: rtl/usb_rx_dpll_pkg.sv
// Shared types for the USB receive clock-recovery block.
// Line states use the full-speed pad encoding {dp, dm}. The speed-dependent
// J/K swap happens only in pads_to_line_state().
package usb_rx_dpll_pkg;

    // 1 selects full speed (J = D+ high), 0 selects low speed (J = D- high)
    localparam bit USB_FULL_SPEED = 1'b1;

    // clk_usb runs at four times the bit rate, so one bit spans four phases
    localparam int DPLL_PHASES = 4;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        K   = 2'b01,
        J   = 2'b10,
        SE1 = 2'b11
    } line_state_t;

    // Map the synchronized pad pair to a line state, applying the speed mapping
    function automatic line_state_t pads_to_line_state(input logic dp, input logic dm);
        line_state_t ls;
        case ({dp, dm})
            2'b00:   ls = SE0;
            2'b11:   ls = SE1;
            2'b10:   ls = USB_FULL_SPEED ? J : K;
            default: ls = USB_FULL_SPEED ? K : J;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_rx_dpll_sync.sv
// Multi-flop synchronizer for the asynchronous USB pads.
// Each bit is synchronized independently; all flops clear to 0 on reset.
module usb_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift each pad sample through the synchronizer chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/usb_rx_dpll.sv
// USB receive DPLL: synchronizes D+/D-, decodes the line state, and keeps
// a 4-phase counter aligned to bit edges so one strobe lands mid-bit.
// Optional macro USB_RX_DPLL_GLITCH_FILTER_EN: a new line state is only
// accepted after two equal consecutive samples, which adds one cycle of latency.
module usb_rx_dpll
    import usb_rx_dpll_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_BITS   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       dp_i,
    input  logic       dm_i,
    output logic [1:0] line_state_o,
    output logic       se0_o,
    output logic       rx_d_o,
    output logic       bit_strobe_o,
    output logic       phase_err_o,
    output logic       locked_o
);

    localparam logic [1:0] CNT_RELOAD  = 2'd1;
    localparam logic [1:0] CNT_MID     = 2'd2;
    localparam logic [1:0] CNT_LAST    = 2'(DPLL_PHASES - 1);
    localparam logic [7:0] LOCK_THRESH = 8'(LOCK_BITS);
    localparam logic [7:0] LOCK_MAX    = 8'hFF;

    logic [1:0]  padsSync;
    line_state_t rawState;
    line_state_t curState;
    logic        edgeDet;
    logic        errDet;

    line_state_t prevState_q, prevState_d;
    logic        active_q, active_d;
    logic [1:0]  cnt_q, cnt_d;
    line_state_t lineState_q, lineState_d;
    logic        se0_q, se0_d;
    logic        rxD_q, rxD_d;
    logic        strobe_q, strobe_d;
    logic        phaseErr_q, phaseErr_d;
    logic        errSeen_q, errSeen_d;
    logic [7:0]  lockCnt_q, lockCnt_d;
    logic        locked_q, locked_d;

    usb_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (2)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({dp_i, dm_i}),
        .q_o    (padsSync)
    );

    assign rawState = pads_to_line_state(padsSync[1], padsSync[0]);

`ifdef USB_RX_DPLL_GLITCH_FILTER_EN
    line_state_t lastRaw_q;

    // Remember the previous raw sample so a new state must repeat before it counts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lastRaw_q <= SE0;
        end else begin
            lastRaw_q <= rawState;
        end
    end

    assign curState = (rawState == lastRaw_q) ? rawState : prevState_q;
`else
    assign curState = rawState;
`endif

    // Edge detection, phase counter, strobe and captured data
    always_comb begin
        edgeDet     = (curState != prevState_q);
        errDet      = edgeDet && ((active_q && (cnt_q == CNT_MID)) || (curState == SE1));
        prevState_d = curState;
        active_d    = active_q | edgeDet;

        // The counter idles after reset until the first edge gives it a phase
        if (edgeDet) begin
            cnt_d = CNT_RELOAD;
        end else if (!active_q) begin
            cnt_d = cnt_q;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 2'd1;
        end

        strobe_d    = (cnt_d == CNT_MID);
        rxD_d       = strobe_d ? (curState == J) : rxD_q;
        lineState_d = curState;
        se0_d       = (curState == SE0);
        phaseErr_d  = errDet;
    end

    // Lock tracking: count clean strobes, restart on any phase error
    always_comb begin
        lockCnt_d = lockCnt_q;
        errSeen_d = errSeen_q;
        if (phaseErr_q) begin
            lockCnt_d = '0;
            errSeen_d = 1'b1;
        end else if (strobe_q) begin
            errSeen_d = 1'b0;
            if (!errSeen_q && (lockCnt_q != LOCK_MAX)) begin
                lockCnt_d = lockCnt_q + 8'd1;
            end
        end
        locked_d = (lockCnt_d >= LOCK_THRESH);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prevState_q <= SE0;
            active_q    <= 1'b0;
            cnt_q       <= '0;
            lineState_q <= SE0;
            se0_q       <= 1'b0;
            rxD_q       <= 1'b0;
            strobe_q    <= 1'b0;
            phaseErr_q  <= 1'b0;
            errSeen_q   <= 1'b0;
            lockCnt_q   <= '0;
            locked_q    <= 1'b0;
        end else begin
            prevState_q <= prevState_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            lineState_q <= lineState_d;
            se0_q       <= se0_d;
            rxD_q       <= rxD_d;
            strobe_q    <= strobe_d;
            phaseErr_q  <= phaseErr_d;
            errSeen_q   <= errSeen_d;
            lockCnt_q   <= lockCnt_d;
            locked_q    <= locked_d;
        end
    end

    assign line_state_o = lineState_q;
    assign se0_o        = se0_q;
    assign rx_d_o       = rxD_q;
    assign bit_strobe_o = strobe_q;
    assign phase_err_o  = phaseErr_q;
    assign locked_o     = locked_q;

endmodule

// File: tb/tb_usb_rx_dpll.sv
// Directed bench for usb_rx_dpll at full speed with default parameters.
// LAT is the pad-change-to-strobe latency in clocks for the build under test.
module tb_usb_rx_dpll;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

`ifdef USB_RX_DPLL_GLITCH_FILTER_EN
    localparam int  LAT      = 5;
    localparam bit  FILTERED = 1'b1;
`else
    localparam int  LAT      = 4;
    localparam bit  FILTERED = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       dp;
    logic       dm;
    logic [1:0] lineState;
    logic       se0;
    logic       rxD;
    logic       bitStrobe;
    logic       phaseErr;
    logic       locked;

    int compared   = 0;
    int mismatched = 0;
    int lineChanges;
    logic [1:0] lastLine;

    usb_rx_dpll #(
        .SYNC_STAGES (2),
        .LOCK_BITS   (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dp_i         (dp),
        .dm_i         (dm),
        .line_state_o (lineState),
        .se0_o        (se0),
        .rx_d_o       (rxD),
        .bit_strobe_o (bitStrobe),
        .phase_err_o  (phaseErr),
        .locked_o     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the pads with a line state in full-speed encoding
    task automatic applyStimulus(input logic [1:0] ls);
        {dp, dm} = ls;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (lineState !== lastLine) lineChanges++;
        lastLine = lineState;
    endtask

    // Step until a strobe is seen (bounded), then move to the on-time edge point
    task automatic align();
        bit found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (bitStrobe === 1'b1) found = 1'b1;
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL align_strobe: got no strobe in 16 cycles, expected one");
        end
        repeat ((8 - LAT) % 4) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(LS_J);
        repeat (3) @(posedge clk);
        #1;
        compared++; if (lineState !== LS_SE0) begin mismatched++; $display("[TB] FAIL reset_line: got %b expected %b", lineState, LS_SE0); end
        compared++; if (se0 !== 1'b0)         begin mismatched++; $display("[TB] FAIL reset_se0: got %b expected 0", se0); end
        compared++; if (rxD !== 1'b0)         begin mismatched++; $display("[TB] FAIL reset_rxd: got %b expected 0", rxD); end
        compared++; if (bitStrobe !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_strobe: got %b expected 0", bitStrobe); end
        compared++; if (phaseErr !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", phaseErr); end
        compared++; if (locked !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
        lastLine = lineState;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        bit expStrobe;
        bit expLocked;
        for (int k = 1; k <= 40; k++) begin
            step();
            expStrobe = (k >= LAT) && (((k - LAT) % 4) == 0);
            expLocked = (k >= LAT + 29);
            compared++;
            if (bitStrobe !== expStrobe) begin
                mismatched++;
                $display("[TB] FAIL idle_strobe k=%0d: got %b expected %b", k, bitStrobe, expStrobe);
            end
            compared++;
            if (locked !== expLocked) begin
                mismatched++;
                $display("[TB] FAIL idle_locked k=%0d: got %b expected %b", k, locked, expLocked);
            end
            if (expStrobe) begin
                compared++;
                if (rxD !== 1'b1 || lineState !== LS_J) begin
                    mismatched++;
                    $display("[TB] FAIL idle_data k=%0d: got rx=%b line=%b expected rx=1 line=%b", k, rxD, lineState, LS_J);
                end
            end
        end
    endtask

    task automatic test_jitter();
        int lens [10] = '{4, 4, 3, 5, 4, 5, 3, 4, 4, 4};
        bit rxLog [$];
        int r = 0;
        int errs = 0;
        int unlocked = 0;
        align();
        for (int i = 0; i < 10 + (LAT - 4); i++) begin
            if (i < 10) applyStimulus(((i % 2) == 0) ? LS_K : LS_J);
            for (int j = 0; j < ((i < 10) ? lens[i] : 1); j++) begin
                step();
                r++;
                if (r >= 2 && bitStrobe === 1'b1) rxLog.push_back(rxD);
                if (phaseErr !== 1'b0) errs++;
                if (locked !== 1'b1) unlocked++;
            end
        end
        compared++;
        if (rxLog.size() != 10) begin
            mismatched++;
            $display("[TB] FAIL jitter_strobes: got %0d strobes expected 10", rxLog.size());
        end
        for (int i = 0; i < 10 && i < rxLog.size(); i++) begin
            compared++;
            if (rxLog[i] !== ((i % 2) == 1)) begin
                mismatched++;
                $display("[TB] FAIL jitter_rxd bit=%0d: got %b expected %b", i, rxLog[i], ((i % 2) == 1));
            end
        end
        compared++;
        if (errs != 0) begin mismatched++; $display("[TB] FAIL jitter_err: got %0d pulses expected 0", errs); end
        compared++;
        if (unlocked != 0) begin mismatched++; $display("[TB] FAIL jitter_lock: got %0d unlocked cycles expected 0", unlocked); end
    endtask

    task automatic test_half_bit();
        logic [1:0] ls = LS_J;
        int errs = 0;
        align();
        for (int r = 1; r <= 40; r++) begin
            step();
            if (phaseErr === 1'b1) errs++;
            if (r == LAT + 1) begin
                compared++;
                if (phaseErr !== 1'b1) begin mismatched++; $display("[TB] FAIL half_err_pulse: got %b expected 1", phaseErr); end
                compared++;
                if (locked !== 1'b1) begin mismatched++; $display("[TB] FAIL half_lock_hold: got %b expected 1", locked); end
            end
            if (r == LAT + 2) begin
                compared++;
                if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL half_lock_drop: got %b expected 0", locked); end
            end
            if (r == LAT + 34) begin
                compared++;
                if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL half_relock_early: got %b expected 0", locked); end
            end
            if (r == LAT + 35) begin
                compared++;
                if (locked !== 1'b1) begin mismatched++; $display("[TB] FAIL half_relock: got %b expected 1", locked); end
            end
            if ((r % 4) == 2 && r <= 38) begin
                ls = (ls == LS_J) ? LS_K : LS_J;
                applyStimulus(ls);
            end
        end
        compared++;
        if (errs != 1) begin mismatched++; $display("[TB] FAIL half_err_count: got %0d expected 1", errs); end
    endtask

    task automatic test_eop();
        int strobes = 0;
        int errs = 0;
        int unlocked = 0;
        align();
        applyStimulus(LS_SE0);
        for (int r = 1; r <= LAT + 8; r++) begin
            step();
            if (r >= 2 && bitStrobe === 1'b1) strobes++;
            if (phaseErr !== 1'b0) errs++;
            if (locked !== 1'b1) unlocked++;
            if (r == LAT || r == LAT + 4) begin
                compared++;
                if (bitStrobe !== 1'b1 || rxD !== 1'b0 || lineState !== LS_SE0 || se0 !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL eop_se0 r=%0d: got strobe=%b rx=%b line=%b se0=%b expected 1 0 00 1", r, bitStrobe, rxD, lineState, se0);
                end
            end
            if (r == LAT + 8) begin
                compared++;
                if (bitStrobe !== 1'b1 || rxD !== 1'b1 || lineState !== LS_J || se0 !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL eop_j: got strobe=%b rx=%b line=%b se0=%b expected 1 1 10 0", bitStrobe, rxD, lineState, se0);
                end
            end
            if (r == 8) applyStimulus(LS_J);
        end
        compared++;
        if (strobes != 3) begin mismatched++; $display("[TB] FAIL eop_strobes: got %0d expected 3", strobes); end
        compared++;
        if (errs != 0 || unlocked != 0) begin
            mismatched++;
            $display("[TB] FAIL eop_lock: got %0d errs %0d unlocked cycles expected 0 0", errs, unlocked);
        end
    endtask

    task automatic test_se1();
        int errs = 0;
        align();
        applyStimulus(LS_SE1);
        for (int r = 1; r <= LAT + 4; r++) begin
            step();
            if (phaseErr === 1'b1) errs++;
            if (r == LAT - 1) begin
                compared++;
                if (phaseErr !== 1'b1) begin mismatched++; $display("[TB] FAIL se1_err: got %b expected 1", phaseErr); end
            end
            if (r == LAT) begin
                compared++;
                if (lineState !== LS_SE1) begin mismatched++; $display("[TB] FAIL se1_line: got %b expected %b", lineState, LS_SE1); end
            end
            if (r == 4) applyStimulus(LS_J);
        end
        compared++;
        if (errs != 1) begin mismatched++; $display("[TB] FAIL se1_err_count: got %0d expected 1", errs); end
    endtask

    task automatic test_reset_mid();
        int strobes = 0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        compared++;
        if ({lineState, se0, rxD, bitStrobe, phaseErr, locked} !== 7'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs: got line=%b se0=%b rx=%b strobe=%b err=%b lock=%b expected all 0",
                     lineState, se0, rxD, bitStrobe, phaseErr, locked);
        end
        applyStimulus(LS_SE0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            step();
            if (bitStrobe === 1'b1) strobes++;
        end
        compared++;
        if (strobes != 0) begin mismatched++; $display("[TB] FAIL midreset_quiet: got %0d strobes expected 0", strobes); end
        applyStimulus(LS_J);
        strobes = 0;
        for (int r = 1; r <= LAT; r++) begin
            step();
            if (r < LAT && bitStrobe === 1'b1) strobes++;
        end
        compared++;
        if (strobes != 0 || bitStrobe !== 1'b1 || rxD !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_first: got early=%0d strobe=%b rx=%b expected 0 1 1", strobes, bitStrobe, rxD);
        end
    endtask

    task automatic test_glitch();
        int errs = 0;
        align();
        lineChanges = 0;
        lastLine = lineState;
        for (int r = 1; r <= LAT + 6; r++) begin
            step();
            if (phaseErr === 1'b1) errs++;
            if (r == LAT) begin
                compared++;
                if (bitStrobe !== FILTERED) begin mismatched++; $display("[TB] FAIL glitch_strobe_a: got %b expected %b", bitStrobe, FILTERED); end
            end
            if (r == LAT + 2) begin
                compared++;
                if (bitStrobe !== !FILTERED) begin mismatched++; $display("[TB] FAIL glitch_strobe_b: got %b expected %b", bitStrobe, !FILTERED); end
            end
            if (r == 1) applyStimulus(LS_K);
            if (r == 2) applyStimulus(LS_J);
        end
        compared++;
        if (lineChanges != (FILTERED ? 0 : 2)) begin
            mismatched++;
            $display("[TB] FAIL glitch_line_changes: got %0d expected %0d", lineChanges, (FILTERED ? 0 : 2));
        end
        compared++;
        if (errs != 0) begin mismatched++; $display("[TB] FAIL glitch_err: got %0d expected 0", errs); end
    endtask

    initial begin
        rst_n = 1'b0;
        dp = 1'b0;
        dm = 1'b0;
        lineChanges = 0;
        lastLine = 2'b00;
        $display("[TB] usb_rx_dpll bench start, LAT=%0d", LAT);
        test_reset();
        test_idle();
        test_jitter();
        test_half_bit();
        test_eop();
        test_se1();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
